data_mem_responder: RTL and testbench

//  Data-memory slave at the far end of the MEM-stage read_en/write_en interface.

---
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory slave for the MEM stage: RV32I byte/half/word loads and stores
// with byte lanes, optional wait states and misalignment reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        busy,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit NOWAIT = (WAIT_STATES == 0);

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_rd, l_wr;
    logic [2:0]  l_f3;
    logic [31:0] l_addr, l_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        start, acc_go, acc_rd, acc_wr, acc_err;
    logic [2:0]  acc_f3;
    logic [31:0] acc_addr, acc_wdata;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] word, ld, wdat;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [3:0]  be;
    logic        unused_addr;

    assign start = (state == IDLE) && (read_en || write_en);

    // Without wait states the access uses the live request; otherwise the latched copy.
    assign acc_go    = NOWAIT ? start : (state == WAIT && cnt == 4'd1);
    assign acc_wr    = NOWAIT ? write_en : l_wr;
    assign acc_rd    = NOWAIT ? (read_en && !write_en) : l_rd;
    assign acc_f3    = NOWAIT ? funct3_in : l_f3;
    assign acc_addr  = NOWAIT ? addr_in : l_addr;
    assign acc_wdata = NOWAIT ? wdata_in : l_wdata;

    assign idx  = acc_addr[AW+1:2];
    assign lane = acc_addr[1:0];
    assign unused_addr = ^acc_addr[31:AW+2];

    assign word = mem[idx];
    assign bsel = word[{lane, 3'b000} +: 8];
    assign hsel = acc_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld = '0;
        acc_err = 1'b1;
        unique case (acc_f3)
            3'd0: begin ld = {{24{bsel[7]}}, bsel}; acc_err = 1'b0; end
            3'd4: begin ld = {24'd0, bsel}; acc_err = 1'b0; end
            3'd1: begin ld = {{16{hsel[15]}}, hsel}; acc_err = acc_addr[0]; end
            3'd5: begin ld = {16'd0, hsel}; acc_err = acc_addr[0]; end
            3'd2: begin ld = word; acc_err = |acc_addr[1:0]; end
            default: begin ld = '0; acc_err = 1'b1; end
        endcase
    end

    always_comb begin
        be = 4'b1111;
        wdat = acc_wdata;
        unique case (acc_f3[1:0])
            2'd0: begin
                be = 4'b0001 << lane;
                wdat = {4{acc_wdata[7:0]}};
            end
            2'd1: begin
                be = acc_addr[1] ? 4'b1100 : 4'b0011;
                wdat = {2{acc_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wdat = acc_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && acc_go && acc_wr && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            rdata_out    <= '0;
            rdata_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            rdata_valid  <= acc_go && acc_rd;
            misalign_err <= acc_go && acc_err;
            if (acc_go && acc_rd) rdata_out <= acc_err ? '0 : ld;
            unique case (state)
                IDLE: begin
                    if (start && !NOWAIT) begin
                        l_rd    <= read_en && !write_en;
                        l_wr    <= write_en;
                        l_f3    <= funct3_in;
                        l_addr  <= addr_in;
                        l_wdata <= wdata_in;
                        cnt     <= WAIT_STATES[3:0];
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 2, 3 wait states)
// checked each cycle against a transaction-level memory model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd_en [3], wr_en [3], vld [3], bsy [3], err [3];
    logic [2:0]  f3 [3];
    logic [31:0] ad [3], wd [3], rdo [3];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .read_en(rd_en[0]), .write_en(wr_en[0]),
        .funct3_in(f3[0]), .addr_in(ad[0]), .wdata_in(wd[0]),
        .rdata_out(rdo[0]), .rdata_valid(vld[0]), .busy(bsy[0]),
        .misalign_err(err[0]));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .read_en(rd_en[1]), .write_en(wr_en[1]),
        .funct3_in(f3[1]), .addr_in(ad[1]), .wdata_in(wd[1]),
        .rdata_out(rdo[1]), .rdata_valid(vld[1]), .busy(bsy[1]),
        .misalign_err(err[1]));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .read_en(rd_en[2]), .write_en(wr_en[2]),
        .funct3_in(f3[2]), .addr_in(ad[2]), .wdata_in(wd[2]),
        .rdata_out(rdo[2]), .rdata_valid(vld[2]), .busy(bsy[2]),
        .misalign_err(err[2]));

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model: memory arrays plus a pending-access record that completes
    // WAIT_STATES edges after acceptance.
    logic [31:0] mm [3][1024];
    logic [31:0] er [3];
    logic        ev [3], ee [3], eb [3];
    bit          pend [3];
    int          due [3];
    bit          p_r [3], p_w [3];
    logic [2:0]  p_f [3];
    logic [31:0] p_a [3], p_d [3];
    int          cyc = 0;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    task automatic model_access(input int i, input bit r, input bit w,
                                input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d);
        bit bad;
        int ix, sh, sh16;
        logic [31:0] m, b, h;
        bad = (f == 3'd3) || (f >= 3'd6) ||
              ((f == 3'd1 || f == 3'd5) && a[0]) ||
              (f == 3'd2 && a[1:0] != 2'd0);
        ix = int'((a >> 2) % 1024);
        sh = int'(a[1:0]) * 8;
        sh16 = a[1] ? 16 : 0;
        m = mm[i][ix];
        b = (m >> sh) & 32'hFF;
        h = (m >> sh16) & 32'hFFFF;
        ee[i] = bad;
        if (w) begin
            if (!bad) begin
                if (f[1:0] == 2'd0)
                    mm[i][ix] = (m & ~(32'hFF << sh)) | ({24'd0, d[7:0]} << sh);
                else if (f[1:0] == 2'd1)
                    mm[i][ix] = (m & ~(32'hFFFF << sh16)) | ({16'd0, d[15:0]} << sh16);
                else
                    mm[i][ix] = d;
            end
        end else if (r) begin
            ev[i] = 1'b1;
            if (bad) er[i] = 32'd0;
            else if (f == 3'd0) er[i] = b[7] ? (b | 32'hFFFFFF00) : b;
            else if (f == 3'd4) er[i] = b;
            else if (f == 3'd1) er[i] = h[15] ? (h | 32'hFFFF0000) : h;
            else if (f == 3'd5) er[i] = h;
            else er[i] = m;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0;
            ee[i] = 1'b0;
            if (!rst_n) begin
                pend[i] = 1'b0;
                er[i] = 32'd0;
            end else if (pend[i]) begin
                if (cyc == due[i]) begin
                    pend[i] = 1'b0;
                    model_access(i, p_r[i], p_w[i], p_f[i], p_a[i], p_d[i]);
                end
            end else if (rd_en[i] || wr_en[i]) begin
                if (ws_of(i) == 0) begin
                    model_access(i, rd_en[i], wr_en[i], f3[i], ad[i], wd[i]);
                end else begin
                    pend[i] = 1'b1;
                    due[i] = cyc + ws_of(i);
                    p_r[i] = rd_en[i];
                    p_w[i] = wr_en[i];
                    p_f[i] = f3[i];
                    p_a[i] = ad[i];
                    p_d[i] = wd[i];
                end
            end
            eb[i] = pend[i];
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("valid[%0d]@%0d", i, cyc), {31'd0, vld[i]}, {31'd0, ev[i]});
                chk($sformatf("err[%0d]@%0d", i, cyc), {31'd0, err[i]}, {31'd0, ee[i]});
                chk($sformatf("busy[%0d]@%0d", i, cyc), {31'd0, bsy[i]}, {31'd0, eb[i]});
                chk($sformatf("rdata[%0d]@%0d", i, cyc), rdo[i], er[i]);
            end
        end
    end

    task automatic setq(input int i, input bit r, input bit w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
        rd_en[i] = r;
        wr_en[i] = w;
        f3[i] = f;
        ad[i] = a;
        wd[i] = d;
    endtask

    task automatic clrq(input int i);
        rd_en[i] = 1'b0;
        wr_en[i] = 1'b0;
    endtask

    task automatic req(input int i, input bit r, input bit w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
        setq(i, r, w, f, a, d);
        @(negedge clk);
        clrq(i);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            setq(i, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            ev[i] = 1'b0; ee[i] = 1'b0; eb[i] = 1'b0; er[i] = 32'd0;
            pend[i] = 1'b0; due[i] = 0;
            for (int k = 0; k < 1024; k++) mm[i][k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset rdata", rdo[0], 32'd0);
        chk("reset busy", {31'd0, bsy[2]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        req(0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        req(0, 1, 0, 3'd2, 32'h10, 32'd0);
        chk("lw 0x10", rdo[0], 32'hDEADBEEF);
        chk("lw valid", {31'd0, vld[0]}, 32'd1);

        req(0, 0, 1, 3'd2, 32'h20, 32'd0);
        req(0, 0, 1, 3'd0, 32'h21, 32'h80);
        req(0, 1, 0, 3'd0, 32'h21, 32'd0);
        chk("lb 0x21", rdo[0], 32'hFFFFFF80);
        req(0, 1, 0, 3'd4, 32'h21, 32'd0);
        chk("lbu 0x21", rdo[0], 32'h00000080);
        req(0, 1, 0, 3'd2, 32'h20, 32'd0);
        chk("lw 0x20", rdo[0], 32'h00008000);

        req(0, 0, 1, 3'd2, 32'h30, 32'h11223344);
        req(0, 0, 1, 3'd1, 32'h31, 32'hABCD);
        chk("sh misalign err", {31'd0, err[0]}, 32'd1);
        req(0, 1, 0, 3'd2, 32'h30, 32'd0);
        chk("word unchanged", rdo[0], 32'h11223344);
        req(0, 1, 0, 3'd2, 32'h33, 32'd0);
        chk("lw 0x33 rdata", rdo[0], 32'd0);
        chk("lw 0x33 err", {31'd0, err[0]}, 32'd1);

        req(0, 1, 1, 3'd2, 32'h40, 32'h1234);
        chk("rd+wr no valid", {31'd0, vld[0]}, 32'd0);
        req(0, 1, 0, 3'd2, 32'h40, 32'd0);
        chk("rd+wr stored", rdo[0], 32'h00001234);

        req(0, 0, 1, 3'd2, 32'h70, 32'h80017FFE);
        req(0, 1, 0, 3'd1, 32'h72, 32'd0);
        chk("lh 0x72", rdo[0], 32'hFFFF8001);
        req(0, 1, 0, 3'd5, 32'h72, 32'd0);
        chk("lhu 0x72", rdo[0], 32'h00008001);
        req(0, 1, 0, 3'd1, 32'h70, 32'd0);
        chk("lh 0x70", rdo[0], 32'h00007FFE);

        req(0, 0, 1, 3'd2, 32'h1060, 32'hA5A50001);
        req(0, 1, 0, 3'd2, 32'h60, 32'd0);
        chk("wrap", rdo[0], 32'hA5A50001);
        req(0, 1, 0, 3'd3, 32'h10, 32'd0);
        chk("illegal f3 err", {31'd0, err[0]}, 32'd1);
        chk("illegal f3 rdata", rdo[0], 32'd0);

        setq(0, 1, 0, 3'd2, 32'h10, 32'd0);
        @(negedge clk);
        chk("b2b first", rdo[0], 32'hDEADBEEF);
        setq(0, 1, 0, 3'd0, 32'h21, 32'd0);
        @(negedge clk);
        clrq(0);
        chk("b2b second", rdo[0], 32'hFFFFFF80);

        req(1, 0, 1, 3'd2, 32'h8, 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        req(1, 1, 0, 3'd2, 32'h8, 32'd0);
        chk("ws2 busy c1", {31'd0, bsy[1]}, 32'd1);
        req(1, 0, 1, 3'd2, 32'h8, 32'h0);
        chk("ws2 busy c2", {31'd0, bsy[1]}, 32'd1);
        chk("ws2 no valid yet", {31'd0, vld[1]}, 32'd0);
        @(negedge clk);
        chk("ws2 valid", {31'd0, vld[1]}, 32'd1);
        chk("ws2 busy off", {31'd0, bsy[1]}, 32'd0);
        chk("ws2 rdata", rdo[1], 32'hCAFEF00D);
        req(1, 1, 0, 3'd2, 32'h8, 32'd0);
        repeat (2) @(negedge clk);
        chk("ws2 ignored write", rdo[1], 32'hCAFEF00D);

        req(2, 0, 1, 3'd2, 32'h50, 32'h55AA55AA);
        repeat (4) @(negedge clk);
        req(2, 0, 1, 3'd2, 32'h50, 32'hFFFFFFFF);
        chk("ws3 busy", {31'd0, bsy[2]}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("ws3 rst busy", {31'd0, bsy[2]}, 32'd0);
        chk("ws3 rst rdata", rdo[2], 32'd0);
        repeat (4) @(negedge clk);
        req(2, 1, 0, 3'd2, 32'h50, 32'd0);
        repeat (3) @(negedge clk);
        chk("ws3 word kept", rdo[2], 32'h55AA55AA);
        chk("ws3 valid", {31'd0, vld[2]}, 32'd1);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
